// File: rtl/secuenciador_niveles.sv
// rtl/secuenciador_niveles.sv - level/lives/hit sequencer for a rhythm game
module secuenciador_niveles #(
   parameter int VIDAS_INI      = 3,
   parameter int ACIERTOS_NIVEL = 20,
   parameter int NIVEL_MAX      = 3,
   parameter int ESPERA_NIVEL   = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       iniciar,
   input  logic       acierto,
   input  logic       fallo,
   input  logic       pausa,
   output logic [1:0] nivel,
   output logic [2:0] vidas,
   output logic [7:0] aciertos,
   output logic [2:0] estado,
   output logic       jugando,
   output logic       stop,
   output logic       reiniciar,
   output logic       sube
);

   typedef enum logic [2:0] {
      INICIAL    = 3'd0,
      JUGANDO    = 3'd1,
      PAUSA      = 3'd2,
      SUBE_NIVEL = 3'd3,
      GAME_OVER  = 3'd4,
      VICTORIA   = 3'd5
   } estado_t;

   localparam logic [2:0] VIDAS_CARGA = 3'(VIDAS_INI);
   localparam logic [7:0] META        = 8'(ACIERTOS_NIVEL);
   localparam logic [1:0] ULTIMO      = 2'(NIVEL_MAX);
   localparam logic [7:0] ESPERA      = 8'(ESPERA_NIVEL);

   estado_t    est;
   logic [7:0] cuenta;
   logic       iniciar_q;
   logic       arranque;

   // Start is a rising edge of the button, so a held level fires only once.
   assign arranque = iniciar & ~iniciar_q;

   // Status flags decode the state register directly, no added latency.
   assign estado  = est;
   assign jugando = (est == JUGANDO);
   assign stop    = (est == INICIAL) || (est == GAME_OVER) || (est == VICTORIA);

   // Game FSM with its counters and one-cycle entry pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         est       <= INICIAL;
         nivel     <= 2'd0;
         vidas     <= 3'd0;
         aciertos  <= 8'd0;
         cuenta    <= 8'd0;
         iniciar_q <= 1'b0;
         reiniciar <= 1'b0;
         sube      <= 1'b0;
      end else begin
         iniciar_q <= iniciar;
         reiniciar <= 1'b0;
         sube      <= 1'b0;
         case (est)
            INICIAL: begin
               if (arranque) begin
                  est      <= JUGANDO;
                  nivel    <= 2'd1;
                  vidas    <= VIDAS_CARGA;
                  aciertos <= 8'd0;
               end
            end
            JUGANDO: begin
               // Pause has priority; a miss beats a simultaneous hit.
               if (pausa) begin
                  est <= PAUSA;
               end else if (fallo) begin
                  if (vidas == 3'd1) begin
                     vidas     <= 3'd0;
                     est       <= GAME_OVER;
                     reiniciar <= 1'b1;
                  end else begin
                     vidas <= vidas - 3'd1;
                  end
               end else if (acierto) begin
                  aciertos <= aciertos + 8'd1;
                  if (aciertos + 8'd1 == META) begin
                     if (nivel < ULTIMO) begin
                        est    <= SUBE_NIVEL;
                        cuenta <= ESPERA;
                        sube   <= 1'b1;
                     end else begin
                        est <= VICTORIA;
                     end
                  end
               end
            end
            PAUSA: begin
               if (!pausa) begin
                  est <= JUGANDO;
               end
            end
            SUBE_NIVEL: begin
               // Countdown starts at ESPERA, so the hold lasts exactly ESPERA cycles.
               if (cuenta == 8'd1) begin
                  est      <= JUGANDO;
                  nivel    <= nivel + 2'd1;
                  aciertos <= 8'd0;
                  cuenta   <= 8'd0;
               end else begin
                  cuenta <= cuenta - 8'd1;
               end
            end
            GAME_OVER, VICTORIA: begin
               if (arranque) begin
                  est      <= INICIAL;
                  nivel    <= 2'd0;
                  vidas    <= 3'd0;
                  aciertos <= 8'd0;
               end
            end
            default: begin
               est      <= INICIAL;
               nivel    <= 2'd0;
               vidas    <= 3'd0;
               aciertos <= 8'd0;
               cuenta   <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_secuenciador_niveles.sv
// tb/tb_secuenciador_niveles.sv - self-checking bench for secuenciador_niveles
module tb_secuenciador_niveles;

   localparam int VI = 3;
   localparam int AN = 20;
   localparam int NM = 3;
   localparam int EN = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ini = 1'b0, aci = 1'b0, fal = 1'b0, pau = 1'b0;
   logic [1:0] nivel;
   logic [2:0] vidas;
   logic [7:0] aciertos;
   logic [2:0] estado;
   logic       jugando, stop, reiniciar, sube;

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_st, m_niv, m_vid, m_aci, m_cnt, m_iq, m_rein, m_sube;

   secuenciador_niveles #(
      .VIDAS_INI(VI), .ACIERTOS_NIVEL(AN), .NIVEL_MAX(NM), .ESPERA_NIVEL(EN)
   ) dut (
      .clk(clk), .reset_n(reset_n), .iniciar(ini), .acierto(aci), .fallo(fal),
      .pausa(pau), .nivel(nivel), .vidas(vidas), .aciertos(aciertos),
      .estado(estado), .jugando(jugando), .stop(stop), .reiniciar(reiniciar),
      .sube(sube)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_model();
      chk("estado", int'(estado), m_st);
      chk("nivel", int'(nivel), m_niv);
      chk("vidas", int'(vidas), m_vid);
      chk("aciertos", int'(aciertos), m_aci);
      chk("jugando", int'(jugando), (m_st == 1) ? 1 : 0);
      chk("stop", int'(stop), (m_st == 0 || m_st == 4 || m_st == 5) ? 1 : 0);
      chk("reiniciar", int'(reiniciar), m_rein);
      chk("sube", int'(sube), m_sube);
   endtask

   // One clock: advance the game rules on the current inputs, then compare.
   task automatic tick();
      int  old;
      bit  start;
      old   = m_st;
      start = ini && (m_iq == 0);
      m_iq  = ini;
      case (m_st)
         0: if (start) begin m_st = 1; m_niv = 1; m_vid = VI; m_aci = 0; end
         1: begin
            if (pau) m_st = 2;
            else if (fal) begin
               m_vid = m_vid - 1;
               if (m_vid == 0) m_st = 4;
            end else if (aci) begin
               m_aci = m_aci + 1;
               if (m_aci == AN) begin
                  if (m_niv < NM) begin m_st = 3; m_cnt = EN; end
                  else m_st = 5;
               end
            end
         end
         2: if (!pau) m_st = 1;
         3: begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin m_st = 1; m_niv = m_niv + 1; m_aci = 0; end
         end
         default: if (start) begin m_st = 0; m_niv = 0; m_vid = 0; m_aci = 0; end
      endcase
      m_rein = (m_st == 4 && old != 4) ? 1 : 0;
      m_sube = (m_st == 3 && old != 3) ? 1 : 0;
      @(posedge clk);
      #1;
      chk_model();
   endtask

   task automatic cyc(input bit i, input bit a, input bit f, input bit p);
      ini = i; aci = a; fal = f; pau = p;
      tick();
   endtask

   // Assert reset between edges, check it acted at once, release on a falling edge.
   task automatic do_reset(input bit ini_hold);
      ini = ini_hold; aci = 0; fal = 0; pau = 0;
      #1;
      reset_n = 1'b0;
      #1;
      m_st = 0; m_niv = 0; m_vid = 0; m_aci = 0; m_cnt = 0; m_iq = 0;
      m_rein = 0; m_sube = 0;
      chk("rst_estado", int'(estado), 0);
      chk("rst_nivel", int'(nivel), 0);
      chk("rst_vidas", int'(vidas), 0);
      chk("rst_aciertos", int'(aciertos), 0);
      chk("rst_jugando", int'(jugando), 0);
      chk("rst_stop", int'(stop), 1);
      chk("rst_reiniciar", int'(reiniciar), 0);
      chk("rst_sube", int'(sube), 0);
      @(posedge clk);
      #1;
      chk_model();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic hits(input int n);
      for (int k = 0; k < n; k++) begin
         cyc(0, 1, 0, 0);
         if (k != n - 1) cyc(0, 0, 0, 0);
      end
   endtask

   initial begin
      m_iq = 0;
      do_reset(0);

      // Level 1 cleared with defaults, then the transition hold.
      cyc(1, 0, 0, 0);
      chk("start_estado", int'(estado), 1);
      chk("start_vidas", int'(vidas), 3);
      ini = 0;
      hits(AN);
      chk("lvl_sube", int'(sube), 1);
      chk("lvl_estado", int'(estado), 3);
      for (int k = 0; k < EN - 1; k++) begin
         cyc(0, 1, 1, 0);
         chk("hold_estado", int'(estado), 3);
      end
      cyc(0, 0, 0, 0);
      chk("after_estado", int'(estado), 1);
      chk("after_nivel", int'(nivel), 2);
      chk("after_aciertos", int'(aciertos), 0);
      chk("after_vidas", int'(vidas), 3);

      // Three misses end the game.
      do_reset(0);
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 1, 0);
         chk("miss_vidas", int'(vidas), 2 - k);
         if (k < 2) cyc(0, 0, 0, 0);
      end
      chk("go_estado", int'(estado), 4);
      chk("go_reiniciar", int'(reiniciar), 1);
      chk("go_stop", int'(stop), 1);
      cyc(0, 0, 0, 0);
      chk("go_pulse_end", int'(reiniciar), 0);
      chk("go_hold", int'(estado), 4);

      // Simultaneous hit and miss at 19 hits.
      do_reset(0);
      cyc(1, 0, 0, 0);
      hits(AN - 1);
      cyc(0, 1, 1, 0);
      chk("both_aciertos", int'(aciertos), 19);
      chk("both_vidas", int'(vidas), 2);
      chk("both_estado", int'(estado), 1);

      // Pause freezes counters for ten cycles.
      cyc(0, 1, 0, 1);
      chk("pause_estado", int'(estado), 2);
      for (int k = 0; k < 9; k++) begin
         cyc(0, 1'($urandom), 1'($urandom), 1);
         chk("pause_hold", int'(estado), 2);
         chk("pause_aciertos", int'(aciertos), 19);
      end
      cyc(0, 0, 0, 0);
      chk("unpause_estado", int'(estado), 1);
      chk("unpause_vidas", int'(vidas), 2);

      // Clear all three levels to victory, then return to idle.
      do_reset(0);
      cyc(1, 0, 0, 0);
      for (int lv = 1; lv <= NM; lv++) begin
         hits(AN);
         if (lv < NM) for (int k = 0; k < EN; k++) cyc(0, 0, 0, 0);
      end
      chk("vic_estado", int'(estado), 5);
      chk("vic_sube", int'(sube), 0);
      cyc(1, 0, 0, 0);
      chk("idle_estado", int'(estado), 0);
      chk("idle_nivel", int'(nivel), 0);

      // Start held through reset release counts as an edge.
      do_reset(1);
      cyc(1, 0, 0, 0);
      chk("rel_start", int'(estado), 1);

      // Reset during level-transition countdown.
      cyc(0, 0, 0, 0);
      hits(AN);
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0);
      chk("mid_sube_estado", int'(estado), 3);
      do_reset(0);

      // Random play against the model.
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 1500; k++) begin
         cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 11) == 0), ($urandom_range(0, 14) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/secuenciador_niveles.md
SECUENCIADOR_NIVELES -- requirements
Module: secuenciador_niveles

Interface
REQ-001 Parameter VIDAS_INI, default 3, lives loaded at game start (range 1..7).
REQ-002 Parameter ACIERTOS_NIVEL, default 20, hits required to clear a level (range 1..255).
REQ-003 Parameter NIVEL_MAX, default 3, last level (range 1..3).
REQ-004 Parameter ESPERA_NIVEL, default 16, level-transition hold in clk cycles (range 1..255).
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 iniciar  input  1  start button level, synchronous to clk.
REQ-008 acierto  input  1  one-cycle pulse per correctly hit note.
REQ-009 fallo  input  1  one-cycle pulse per missed or wrong note.
REQ-010 pausa  input  1  pause request level.
REQ-011 nivel  output  2  current level, 1..NIVEL_MAX; 0 when no game is active.
REQ-012 vidas  output  3  remaining lives.
REQ-013 aciertos  output  8  hits counted in current level.
REQ-014 estado  output  3  state code: INICIAL=0, JUGANDO=1, PAUSA=2, SUBE_NIVEL=3, GAME_OVER=4, VICTORIA=5.
REQ-015 jugando  output  1  high only in JUGANDO.
REQ-016 stop  output  1  high in INICIAL, GAME_OVER and VICTORIA.
REQ-017 reiniciar  output  1  registered one-cycle pulse on entry to GAME_OVER.
REQ-018 sube  output  1  registered one-cycle pulse on entry to SUBE_NIVEL.

Function
REQ-019 Start is the rising edge of iniciar, detected against an internal registered copy (iniciar_q); a held level never re-triggers.
REQ-020 INICIAL: on start edge -> JUGANDO next cycle, nivel=1, vidas=VIDAS_INI, aciertos=0.
REQ-021 JUGANDO, pausa=1 -> PAUSA; acierto/fallo in that same cycle are discarded.
REQ-022 PAUSA: counters frozen, acierto/fallo ignored; pausa=0 -> JUGANDO.
REQ-023 JUGANDO, fallo=1: vidas decrements by 1; if vidas was 1 -> GAME_OVER with vidas=0.
REQ-024 JUGANDO, acierto=1 and fallo=0: aciertos increments; if result equals ACIERTOS_NIVEL -> SUBE_NIVEL when nivel<NIVEL_MAX, else VICTORIA.
REQ-025 Simultaneous acierto and fallo: fallo wins, acierto discarded, aciertos unchanged.
REQ-026 aciertos never wraps; it is cleared on level entry and never exceeds ACIERTOS_NIVEL.
REQ-027 SUBE_NIVEL: internal 8-bit countdown loaded with ESPERA_NIVEL on entry; inputs ignored; after exactly ESPERA_NIVEL cycles in SUBE_NIVEL -> JUGANDO with nivel+1, aciertos=0, vidas unchanged.
REQ-028 GAME_OVER, VICTORIA: all counters hold; start edge -> INICIAL; nivel reads 0 in INICIAL.
REQ-029 jugando, stop and estado are pure decodes of the state register (no extra latency); reiniciar and sube assert in the first cycle the new state is visible.
REQ-030 Unused state codes 6, 7 -> INICIAL on next clock.

Reset
REQ-031 reset_n=0 asynchronously forces estado=INICIAL, nivel=0, vidas=0, aciertos=0, countdown=0, iniciar_q=0, reiniciar=0, sube=0, jugando=0, stop=1.
REQ-032 Reset mid-game (any state) aborts immediately; no pulse output is generated by the reset.
REQ-033 iniciar high at reset release counts as a start edge (iniciar_q=0), so the game enters JUGANDO one cycle after release.

Verification
REQ-034 Defaults; start edge, then 20 acierto pulses -> sube pulse, estado=3 for 16 cycles, then estado=1, nivel=2, aciertos=0, vidas=3.
REQ-035 Start, 3 fallo pulses -> vidas 2,1,0; estado=4 and reiniciar=1 for exactly one cycle after third fallo; stop=1.
REQ-036 In JUGANDO with aciertos=19, acierto and fallo same cycle -> aciertos=19, vidas decremented, no level change.
REQ-037 Pausa high for 10 cycles with acierto/fallo pulses -> estado=2, counters unchanged; pausa low -> estado=1.
REQ-038 Clear levels 1..3 -> after 20th hit on nivel=3 estado=5, no sube pulse; start edge -> estado=0, nivel=0.
REQ-039 reset_n low mid SUBE_NIVEL countdown -> all outputs to REQ-031 values without waiting for a clock edge.
